// File: rtl/tdp_bram_ref_model.sv
// Single-clock true-dual-port RAM reference model: byte-lane writes, per-port read-during-write
// behaviour, optional output register, per-address written tracking and write/write collision flags.
module tdp_bram_ref_model #(
   parameter int ABITS      = 10,
   parameter int DBITS      = 36,
   parameter int BE_BITS    = 9,
   parameter int RDW_MODE_A = 0,
   parameter int RDW_MODE_B = 0,
   parameter int OUT_REG    = 0,
   localparam int DEPTH     = 2 ** ABITS,
   localparam int NBE       = DBITS / BE_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ABITS-1:0] a_a,
   input  logic             we_a,
   input  logic [NBE-1:0]   be_a,
   input  logic [DBITS-1:0] wd_a,
   input  logic             re_a,
   output logic [DBITS-1:0] rd_a,
   output logic             rd_valid_a,
   input  logic [ABITS-1:0] a_b,
   input  logic             we_b,
   input  logic [NBE-1:0]   be_b,
   input  logic [DBITS-1:0] wd_b,
   input  logic             re_b,
   output logic [DBITS-1:0] rd_b,
   output logic             rd_valid_b,
   output logic             collision,
   output logic             collision_sticky
);

   logic [DBITS-1:0] mem [DEPTH];
   logic [DEPTH-1:0] written_reg;
   logic [DEPTH-1:0] written_next;

   // Index 0 is port A, index 1 is port B.
   logic [1:0][ABITS-1:0] addr;
   logic [1:0]            we;
   logic [1:0]            re;
   logic [1:0][NBE-1:0]   be;
   logic [1:0][DBITS-1:0] wd;
   logic [1:0][DBITS-1:0] old;
   logic [1:0][DBITS-1:0] mask;
   logic [1:0][DBITS-1:0] own;
   logic [1:0][DBITS-1:0] rd_int;
   logic [1:0]            rv_int;

   logic             same_addr;
   logic             coll_now;
   logic [DBITS-1:0] word_a;
   logic             collision_reg;
   logic             sticky_reg;

   assign addr = {a_b, a_a};
   assign we   = {we_b, we_a};
   assign re   = {re_b, re_a};
   assign be   = {be_b, be_a};
   assign wd   = {wd_b, wd_a};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         localparam int MODE = (gi == 0) ? RDW_MODE_A : RDW_MODE_B;

         logic             load;
         logic [DBITS-1:0] d_next;
         logic             v_next;
         logic [DBITS-1:0] d_reg;
         logic             v_reg;

         assign old[gi] = mem[addr[gi]];

         for (genvar li = 0; li < NBE; li++) begin : g_lane
            assign mask[gi][li*BE_BITS +: BE_BITS] = {BE_BITS{we[gi] & be[gi][li]}};
         end

         // This port's own write merged over the stored word (WRITE_FIRST view).
         assign own[gi] = (wd[gi] & mask[gi]) | (old[gi] & ~mask[gi]);

         always_comb begin
            load   = re[gi];
            d_next = old[gi];
            v_next = written_reg[addr[gi]];
            if (MODE == 1) begin
               d_next = own[gi];
               v_next = written_next[addr[gi]];
            end else if (MODE == 2) begin
               load = re[gi] & ~we[gi];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               d_reg <= '0;
               v_reg <= 1'b0;
            end else if (load) begin
               d_reg <= d_next;
               v_reg <= v_next;
            end
         end

         if (OUT_REG != 0) begin : g_out
            logic [DBITS-1:0] d2_reg;
            logic             v2_reg;

            always_ff @(posedge clk) begin
               if (rst) begin
                  d2_reg <= '0;
                  v2_reg <= 1'b0;
               end else begin
                  d2_reg <= d_reg;
                  v2_reg <= v_reg;
               end
            end

            assign rd_int[gi] = d2_reg;
            assign rv_int[gi] = v2_reg;
         end else begin : g_direct
            assign rd_int[gi] = d_reg;
            assign rv_int[gi] = v_reg;
         end
      end
   endgenerate

   assign same_addr = (addr[0] == addr[1]);
   assign coll_now  = we[0] & we[1] & same_addr & (|(be[0] & be[1]));

   // Port A's lanes land on top of port B's merged word when both hit one address.
   assign word_a = (we[1] && same_addr) ? ((wd[0] & mask[0]) | (own[1] & ~mask[0])) : own[0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (we[1]) mem[addr[1]] <= own[1];
         if (we[0]) mem[addr[0]] <= word_a;
      end
   end

   always_comb begin
      written_next = written_reg;
      if (we[0] && (|be[0])) written_next[addr[0]] = 1'b1;
      if (we[1] && (|be[1])) written_next[addr[1]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         written_reg   <= '0;
         collision_reg <= 1'b0;
         sticky_reg    <= 1'b0;
      end else begin
         written_reg   <= written_next;
         collision_reg <= coll_now;
         sticky_reg    <= sticky_reg | coll_now;
      end
   end

   assign rd_a             = rd_int[0];
   assign rd_valid_a       = rv_int[0];
   assign rd_b             = rd_int[1];
   assign rd_valid_b       = rv_int[1];
   assign collision        = collision_reg;
   assign collision_sticky = sticky_reg;

endmodule

// File: tb/tb_tdp_bram_ref_model.sv
// Bench for tdp_bram_ref_model: three instances with different read-during-write / output-register
// settings share one stimulus stream and are checked against an array-based behavioural model.
module tb_tdp_bram_ref_model;

   localparam int AB  = 4;
   localparam int DB  = 36;
   localparam int BB  = 9;
   localparam int NB  = DB / BB;
   localparam int NI  = 3;
   localparam int DEP = 2 ** AB;

   logic          clk = 1'b0;
   logic          rst;
   logic [AB-1:0] a_a, a_b;
   logic          we_a, we_b, re_a, re_b;
   logic [NB-1:0] be_a, be_b;
   logic [DB-1:0] wd_a, wd_b;

   logic [DB-1:0] rd_a_o [NI];
   logic [DB-1:0] rd_b_o [NI];
   logic          va_o   [NI];
   logic          vb_o   [NI];
   logic          coll_o [NI];
   logic          stk_o  [NI];

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   // Instance 0: READ_FIRST/READ_FIRST, no out reg. 1: WRITE_FIRST/NO_CHANGE, out reg. 2: NO_CHANGE/WRITE_FIRST.
   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         tdp_bram_ref_model #(
            .ABITS(AB), .DBITS(DB), .BE_BITS(BB),
            .RDW_MODE_A((gi == 0) ? 0 : ((gi == 1) ? 1 : 2)),
            .RDW_MODE_B((gi == 0) ? 0 : ((gi == 1) ? 2 : 1)),
            .OUT_REG((gi == 1) ? 1 : 0)
         ) u_dut (
            .clk(clk), .rst(rst),
            .a_a(a_a), .we_a(we_a), .be_a(be_a), .wd_a(wd_a), .re_a(re_a),
            .rd_a(rd_a_o[gi]), .rd_valid_a(va_o[gi]),
            .a_b(a_b), .we_b(we_b), .be_b(be_b), .wd_b(wd_b), .re_b(re_b),
            .rd_b(rd_b_o[gi]), .rd_valid_b(vb_o[gi]),
            .collision(coll_o[gi]), .collision_sticky(stk_o[gi])
         );
      end
   endgenerate

   // ---------------- behavioural model ----------------
   logic [DB-1:0] m_mem [DEP];
   bit            m_wr  [DEP];
   logic [DB-1:0] m_d1 [NI][2];
   logic [DB-1:0] m_d2 [NI][2];
   bit            m_v1 [NI][2];
   bit            m_v2 [NI][2];
   bit            m_coll, m_stk;

   function automatic int mode_of(int k, int p);
      if (k == 0) return 0;
      if (k == 1) return (p == 0) ? 1 : 2;
      return (p == 0) ? 2 : 1;
   endfunction

   task automatic model_step();
      logic [AB-1:0] ad [2];
      bit            w [2];
      bit            r [2];
      logic [NB-1:0] b [2];
      logic [DB-1:0] d [2];
      logic [DB-1:0] old [2];
      logic [DB-1:0] own [2];
      bit            wb [2];
      logic [DB-1:0] nm;
      ad[0] = a_a; w[0] = we_a; r[0] = re_a; b[0] = be_a; d[0] = wd_a;
      ad[1] = a_b; w[1] = we_b; r[1] = re_b; b[1] = be_b; d[1] = wd_b;
      if (rst) begin
         for (int k = 0; k < NI; k++)
            for (int p = 0; p < 2; p++) begin
               m_d1[k][p] = '0; m_d2[k][p] = '0; m_v1[k][p] = 0; m_v2[k][p] = 0;
            end
         for (int i = 0; i < DEP; i++) m_wr[i] = 0;
         m_coll = 0;
         m_stk  = 0;
         return;
      end
      for (int p = 0; p < 2; p++) begin
         old[p] = m_mem[ad[p]];
         wb[p]  = m_wr[ad[p]];
         own[p] = old[p];
         for (int l = 0; l < NB; l++)
            if (w[p] && b[p][l]) own[p][l*BB +: BB] = d[p][l*BB +: BB];
      end
      // B applied first, then A, so A owns any shared lane.
      for (int p = 1; p >= 0; p--) begin
         if (w[p]) begin
            nm = m_mem[ad[p]];
            for (int l = 0; l < NB; l++)
               if (b[p][l]) nm[l*BB +: BB] = d[p][l*BB +: BB];
            m_mem[ad[p]] = nm;
            if (|b[p]) m_wr[ad[p]] = 1;
         end
      end
      m_coll = w[0] && w[1] && (ad[0] == ad[1]) && (|(b[0] & b[1]));
      m_stk  = m_stk | m_coll;
      for (int k = 0; k < NI; k++)
         for (int p = 0; p < 2; p++) begin
            m_d2[k][p] = m_d1[k][p];
            m_v2[k][p] = m_v1[k][p];
            if (r[p]) begin
               case (mode_of(k, p))
                  0: begin m_d1[k][p] = old[p]; m_v1[k][p] = wb[p]; end
                  1: begin m_d1[k][p] = own[p]; m_v1[k][p] = m_wr[ad[p]]; end
                  default: if (!w[p]) begin m_d1[k][p] = old[p]; m_v1[k][p] = wb[p]; end
               endcase
            end
         end
   endtask

   function automatic logic [2*DB+3:0] model_view(int k);
      if (k == 1)
         return {m_d2[k][0], m_v2[k][0], m_d2[k][1], m_v2[k][1], m_coll, m_stk};
      return {m_d1[k][0], m_v1[k][0], m_d1[k][1], m_v1[k][1], m_coll, m_stk};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      a_a = '0; we_a = 0; be_a = '0; wd_a = '0; re_a = 0;
      a_b = '0; we_b = 0; be_b = '0; wd_b = '0; re_b = 0;
   endtask

   task automatic set_a(input logic [AB-1:0] ad, input bit w, input logic [NB-1:0] b,
                        input logic [DB-1:0] d, input bit r);
      a_a = ad; we_a = w; be_a = b; wd_a = d; re_a = r;
   endtask

   task automatic set_b(input logic [AB-1:0] ad, input bit w, input logic [NB-1:0] b,
                        input logic [DB-1:0] d, input bit r);
      a_b = ad; we_b = w; be_b = b; wd_b = d; re_b = r;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [2*DB+3:0] got;
      idle();
      rst = 1;
      set_a(0, 1, 4'hF, 36'h5A5, 1);
      cycle();
      for (int k = 0; k < NI; k++) begin
         got = {rd_a_o[k], va_o[k], rd_b_o[k], vb_o[k], coll_o[k], stk_o[k]};
         n_total++;
         if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs dut=%0d got=%h want=0", k, got);
         end
      end
      rst = 0;
      idle();
      set_a(0, 0, 0, 0, 1);
      cycle();
      n_total++;
      if (va_o[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_bitmap got=%b want=0", va_o[0]);
      end
      n_total++;
      if (rd_a_o[0] !== 36'h0) begin
         n_bad++;
         $display("FAIL reset_write_dropped got=%h want=0", rd_a_o[0]);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      idle();
      set_a(5, 1, 4'hF, 36'h123456789, 0);
      cycle();
      idle();
      set_b(5, 0, 0, 0, 1);
      cycle();
      n_total++;
      if (rd_b_o[0] !== 36'h123456789 || vb_o[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_lat1 got=%h/%b want=123456789/1", rd_b_o[0], vb_o[0]);
      end
      n_total++;
      if (rd_b_o[1] !== 36'h0) begin
         n_bad++;
         $display("FAIL basic_outreg_early got=%h want=0", rd_b_o[1]);
      end
      idle();
      cycle();
      n_total++;
      if (rd_b_o[1] !== 36'h123456789 || vb_o[1] !== 1'b1) begin
         n_bad++;
         $display("FAIL basic_lat2 got=%h/%b want=123456789/1", rd_b_o[1], vb_o[1]);
      end
      $display("test_basic done");
   endtask

   task automatic test_byte_enables();
      logic [DB-1:0] want;
      want = {9'h1FF, 9'h000, 9'h1FF, 9'h000};
      idle();
      set_a(3, 1, 4'hF, {4{9'h1FF}}, 0);
      cycle();
      set_a(3, 1, 4'b0101, 36'h0, 0);
      cycle();
      set_a(3, 0, 0, 0, 1);
      cycle();
      n_total++;
      if (rd_a_o[0] !== want || va_o[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL byte_enable got=%h/%b want=%h/1", rd_a_o[0], va_o[0], want);
      end
      n_total++;
      if (rd_a_o[2] !== want) begin
         n_bad++;
         $display("FAIL byte_enable_nc got=%h want=%h", rd_a_o[2], want);
      end
      $display("test_byte_enables done");
   endtask

   task automatic test_rdw();
      idle();
      set_a(7, 1, 4'hF, 36'hAAA, 0);
      set_b(6, 1, 4'hF, 36'h777, 0);
      cycle();
      idle();
      set_a(6, 0, 0, 0, 1);
      cycle();
      set_a(7, 1, 4'hF, 36'h555, 1);
      cycle();
      n_total++;
      if (rd_a_o[0] !== 36'hAAA || va_o[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL rdw_read_first got=%h/%b want=aaa/1", rd_a_o[0], va_o[0]);
      end
      n_total++;
      if (rd_a_o[2] !== 36'h777) begin
         n_bad++;
         $display("FAIL rdw_no_change got=%h want=777", rd_a_o[2]);
      end
      idle();
      cycle();
      n_total++;
      if (rd_a_o[1] !== 36'h555 || va_o[1] !== 1'b1) begin
         n_bad++;
         $display("FAIL rdw_write_first got=%h/%b want=555/1", rd_a_o[1], va_o[1]);
      end
      n_total++;
      if (rd_a_o[2] !== 36'h777 || rd_a_o[0] !== 36'hAAA) begin
         n_bad++;
         $display("FAIL rdw_hold got=%h,%h want=777,aaa", rd_a_o[2], rd_a_o[0]);
      end
      $display("test_rdw done");
   endtask

   task automatic test_collision();
      idle();
      set_a(9, 1, 4'hF, 36'h111, 0);
      set_b(9, 1, 4'hF, 36'h222, 0);
      cycle();
      n_total++;
      if (coll_o[0] !== 1'b1 || stk_o[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL collision_pulse got=%b/%b want=1/1", coll_o[0], stk_o[0]);
      end
      idle();
      cycle();
      n_total++;
      if (coll_o[0] !== 1'b0 || stk_o[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL collision_one_cycle got=%b/%b want=0/1", coll_o[0], stk_o[0]);
      end
      set_a(9, 0, 0, 0, 1);
      cycle();
      n_total++;
      if (rd_a_o[0] !== 36'h111) begin
         n_bad++;
         $display("FAIL collision_a_wins got=%h want=111", rd_a_o[0]);
      end
      idle();
      set_a(9, 1, 4'b0011, 36'hAAAAAAAAA, 0);
      set_b(9, 1, 4'b1100, 36'h555555555, 0);
      cycle();
      n_total++;
      if (coll_o[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL disjoint_no_collision got=%b want=0", coll_o[0]);
      end
      idle();
      set_b(9, 0, 0, 0, 1);
      cycle();
      n_total++;
      if (rd_b_o[0] !== 36'h55556AAAA) begin
         n_bad++;
         $display("FAIL disjoint_merge got=%h want=55556aaaa", rd_b_o[0]);
      end
      $display("test_collision done");
   endtask

   task automatic test_cross_raw();
      idle();
      set_a(2, 1, 4'hF, 36'h0F0, 0);
      cycle();
      idle();
      set_a(2, 1, 4'hF, 36'hF0F, 0);
      set_b(2, 0, 0, 0, 1);
      cycle();
      n_total++;
      if (rd_b_o[0] !== 36'h0F0 || rd_b_o[2] !== 36'h0F0) begin
         n_bad++;
         $display("FAIL cross_old got=%h,%h want=0f0,0f0", rd_b_o[0], rd_b_o[2]);
      end
      idle();
      set_b(2, 0, 0, 0, 1);
      cycle();
      n_total++;
      if (rd_b_o[0] !== 36'hF0F) begin
         n_bad++;
         $display("FAIL cross_new got=%h want=f0f", rd_b_o[0]);
      end
      $display("test_cross_raw done");
   endtask

   task automatic test_reset_mid();
      logic [2*DB+3:0] got;
      idle();
      set_a(4, 1, 4'hF, 36'h444, 0);
      cycle();
      set_a(4, 0, 0, 0, 1);
      cycle();
      rst = 1;
      set_a(4, 1, 4'hF, 36'h999, 1);
      for (int c = 0; c < 2; c++) begin
         cycle();
         for (int k = 0; k < 2; k++) begin
            got = {rd_a_o[k], va_o[k], rd_b_o[k], vb_o[k], coll_o[k], stk_o[k]};
            n_total++;
            if (got !== '0) begin
               n_bad++;
               $display("FAIL reset_mid cyc=%0d dut=%0d got=%h want=0", c, k, got);
            end
         end
      end
      rst = 0;
      idle();
      set_a(4, 0, 0, 0, 1);
      cycle();
      n_total++;
      if (rd_a_o[0] !== 36'h444 || va_o[0] !== 1'b0 || rd_a_o[1] !== 36'h0) begin
         n_bad++;
         $display("FAIL reset_retain got=%h/%b,%h want=444/0,0", rd_a_o[0], va_o[0], rd_a_o[1]);
      end
      idle();
      cycle();
      n_total++;
      if (rd_a_o[1] !== 36'h444 || va_o[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_retain_outreg got=%h/%b want=444/0", rd_a_o[1], va_o[1]);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      logic [2*DB+3:0] got, want;
      for (int i = 0; i < 1500; i++) begin
         rst  = ($urandom_range(99) < 2);
         a_a  = AB'($urandom_range(DEP - 1));
         a_b  = ($urandom_range(1) == 1) ? a_a : AB'($urandom_range(DEP - 1));
         we_a = 1'($urandom_range(1));
         we_b = 1'($urandom_range(1));
         re_a = ($urandom_range(9) < 7);
         re_b = ($urandom_range(9) < 7);
         be_a = NB'($urandom());
         be_b = NB'($urandom());
         wd_a = DB'({$urandom(), $urandom()});
         wd_b = DB'({$urandom(), $urandom()});
         cycle();
         for (int k = 0; k < NI; k++) begin
            got  = {rd_a_o[k], va_o[k], rd_b_o[k], vb_o[k], coll_o[k], stk_o[k]};
            want = model_view(k);
            n_total++;
            if (got !== want) begin
               n_bad++;
               $display("FAIL random cyc=%0d dut=%0d got=%h want=%h", i, k, got, want);
            end
         end
      end
      rst = 0;
      idle();
      $display("test_random done");
   endtask

   initial begin
      for (int i = 0; i < DEP; i++) begin
         m_mem[i] = '0;
         m_wr[i]  = 0;
      end
      for (int k = 0; k < NI; k++)
         for (int p = 0; p < 2; p++) begin
            m_d1[k][p] = '0; m_d2[k][p] = '0; m_v1[k][p] = 0; m_v2[k][p] = 0;
         end
      m_coll = 0;
      m_stk  = 0;
      idle();
      rst = 1;
      cycle();
      cycle();
      rst = 0;
      // Power-up memory content is zero; writing it explicitly keeps RTL and model aligned.
      for (int i = 0; i < DEP; i++) begin
         set_a(AB'(i), 1, 4'hF, 36'h0, 0);
         cycle();
      end
      idle();
      test_reset();
      test_basic();
      test_byte_enables();
      test_rdw();
      test_collision();
      test_cross_raw();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/tdp_bram_ref_model.md
Name: tdp_bram_ref_model

Overview:
- Parametrised single-clock true-dual-port BRAM behavioural model, used as the "gold" side in BRAM formal miters and simulation benches.
- Generalises the fixed two-port checking flow with:
  - byte enables;
  - per-port read-during-write modes;
  - optional output register stage;
  - per-address written-tracking (read-valid);
  - explicit same-cycle collision reporting.

Parameters:
- ABITS, 10, address width; DEPTH = 2**ABITS words.
- DBITS, 36, data width per port (both ports equal); must be a multiple of BE_BITS.
- BE_BITS, 9, bits per byte-enable lane; NBE = DBITS/BE_BITS.
- RDW_MODE_A, 0, port A same-port read-during-write: 0=READ_FIRST, 1=WRITE_FIRST, 2=NO_CHANGE.
- RDW_MODE_B, 0, same encoding for port B.
- OUT_REG, 0, 1 adds an output pipeline register on both read paths.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- a_a  input  ABITS  port A address.
- we_a  input  1  port A write enable.
- be_a  input  NBE  port A byte enables (ignored when we_a=0).
- wd_a  input  DBITS  port A write data.
- re_a  input  1  port A read enable.
- rd_a  output  DBITS  port A read data.
- rd_valid_a  output  1  the address behind rd_a had at least one write since reset.
- a_b, we_b, be_b, wd_b, re_b, rd_b, rd_valid_b: same as port A, for port B.
- collision  output  1  1-cycle pulse on write/write to the same address with overlapping byte enables.
- collision_sticky  output  1  set by collision; cleared only by rst.

Behaviour:
- Memory array: DEPTH x DBITS, initial value 0.
  - Not cleared by rst.
  - The written-bitmap (DEPTH bits) is cleared by rst.
- Write: on posedge with we_x=1 and rst=0:
  - each lane i with be_x[i]=1 updates bits [i*BE_BITS +: BE_BITS];
  - written[a_x] is set if any be_x bit is 1.
- Read, OUT_REG=0:
  - re_x=1 at edge N gives rd_x valid after edge N (latency 1).
  - re_x=0 holds rd_x and rd_valid_x.
- Read, OUT_REG=1: one additional register stage, latency 2; the second stage always loads.
- Same-port read-during-write (re_x=1, we_x=1):
  - READ_FIRST: rd_x = old word.
  - WRITE_FIRST: rd_x = merged word (new lanes where be=1, old lanes elsewhere).
  - NO_CHANGE: rd_x and rd_valid_x hold.
- rd_valid_x:
  - registered alongside rd_x;
  - reflects written[] before the edge for READ_FIRST;
  - reflects written[] after the edge for WRITE_FIRST.
- Cross-port read/write on the same address in the same cycle: the reader always sees the old word (READ_FIRST), whatever its mode.
- Write/write, same address, any be lane enabled on both ports:
  - collision=1 for the following cycle;
  - collision_sticky set;
  - port A wins overlapping lanes; non-overlapping lanes of both ports are written.
- Same address with disjoint byte enables: not a collision; both writes take effect.
- rst=1 (takes priority over all ports, any cycle, including mid-pipeline):
  - rd_a, rd_b, both OUT_REG stages, rd_valid_*, collision and collision_sticky go to 0;
  - the written-bitmap is cleared;
  - writes presented in the reset cycle are dropped.
- Address wrap: none. Every address is in range by construction (DEPTH = 2**ABITS).

Test Plan:
- Basic write/read:
  - Stimulus: rst, then A writes 0x123456789 to addr 5 with be=all-ones; next cycle B reads addr 5.
  - Required: rd_b=0x123456789 and rd_valid_b=1 one cycle later (OUT_REG=0); two cycles later with OUT_REG=1.
- Byte enables:
  - Stimulus: A writes 0x1FF_1FF_1FF_1FF to addr 3; then A writes 0 with be=4'b0101; then read addr 3.
  - Required: rd_a=0x1FF_000_1FF_000.
- RDW modes:
  - Stimulus: addr 7 holds 0xAAA; A writes 0x555 with re_a=1.
  - Required: rd_a=0xAAA (READ_FIRST); 0x555 (WRITE_FIRST); previous rd_a unchanged (NO_CHANGE).
- Collision:
  - Stimulus 1: A and B both write addr 9 (A=0x111, B=0x222, full be).
  - Required: collision pulse for 1 cycle; collision_sticky=1; addr 9 reads 0x111.
  - Stimulus 2: the same with disjoint be.
  - Required: no collision; merged word.
- Cross-port RAW:
  - Stimulus: B reads addr 2 (holding 0x0F0) while A writes 0xF0F to addr 2.
  - Required: rd_b=0x0F0; next B read returns 0xF0F.
- Reset mid-operation:
  - Stimulus: write addr 4; assert rst while re_a=1 on addr 4 with OUT_REG=1; then read addr 4.
  - Required: all outputs 0 during and after rst; memory contents retained; the read after rst gives rd_valid_a=0.
